i2c_multi_target_tester: RTL and testbench

Parametrised self-checking I2C traffic sequencer, the next generation of the single-target controller test block. Sits between the board-level test top and a transaction-level I2C master. For each of NUM_TARGETS slave addresses it writes a burst of known bytes, reads them back and compares. It counts errors, NACKs and timeouts, captures the first mismatch, and reports pass/done on status outputs and LEDs.

---
 rtl/i2c_test_pkg.sv | 43 ++++
 rtl/i2c_multi_target_tester_if.sv | 27 ++
 rtl/i2c_test_pattern_chk.sv | 27 ++
 rtl/i2c_multi_target_tester.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_i2c_multi_target_tester.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_test_pkg.sv
// Shared types and constants for the multi-target I2C traffic sequencer.
package i2c_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } test_state_e;

  // Bit offsets of the fields inside first_err.
  localparam int FE_TGT_LSB = 24;
  localparam int FE_IDX_LSB = 16;
  localparam int FE_EXP_LSB = 8;
  localparam int FE_GOT_LSB = 0;

  // Sentinel index/data values recorded for non-data errors.
  localparam logic [7:0] IDX_NACK    = 8'hFF;
  localparam logic [7:0] IDX_TIMEOUT = 8'hFE;
  localparam logic [7:0] GOT_NACK    = 8'hFF;

  function automatic logic [31:0] pack_first_err(logic [7:0] tgt, logic [7:0] idx,
                                                 logic [7:0] exp, logic [7:0] got);
    logic [31:0] r;
    r = 32'd0;
    r[FE_TGT_LSB +: 8] = tgt;
    r[FE_IDX_LSB +: 8] = idx;
    r[FE_EXP_LSB +: 8] = exp;
    r[FE_GOT_LSB +: 8] = got;
    return r;
  endfunction

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(logic [15:0] a, logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/i2c_multi_target_tester_if.sv
// Request/data handshake between the sequencer and a transaction-level I2C master.
interface i2c_multi_target_tester_if;
  logic       txn_valid;
  logic       txn_ready;
  logic       txn_rw;
  logic [6:0] txn_addr;
  logic [7:0] txn_reg;
  logic [4:0] txn_len;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       txn_done;
  logic       txn_nack;

  // Sequencer side: issues requests and write bytes.
  modport master (
    output txn_valid, txn_rw, txn_addr, txn_reg, txn_len, wr_data,
    input  txn_ready, wr_req, rd_valid, rd_data, txn_done, txn_nack
  );

  // I2C master side: accepts requests and returns data/status.
  modport slave (
    input  txn_valid, txn_rw, txn_addr, txn_reg, txn_len, wr_data,
    output txn_ready, wr_req, rd_valid, rd_data, txn_done, txn_nack
  );
endinterface

// File: rtl/i2c_test_pattern_chk.sv
// Pattern generator and read-back comparator: pat(t,i) = seed + t*len + i (mod 256).
module i2c_test_pattern_chk #(
  parameter int         BURST_LEN = 4,
  parameter logic [7:0] PAT_SEED  = 8'hA5
) (
  input  logic [2:0] cur_tgt_i,
  input  logic [4:0] cur_idx_i,
  input  logic [7:0] got_i,
  input  logic [2:0] nxt_tgt_i,
  input  logic [4:0] nxt_idx_i,
  output logic [7:0] exp_o,
  output logic       mismatch_o,
  output logic [7:0] nxt_pat_o
);

  function automatic logic [7:0] pat(logic [2:0] tgt, logic [4:0] idx);
    return PAT_SEED + 8'({5'd0, tgt} * 8'(BURST_LEN)) + {3'd0, idx};
  endfunction

  // Expected byte for the current read slot and the write byte for the next cycle.
  always_comb begin
    exp_o      = pat(cur_tgt_i, cur_idx_i);
    mismatch_o = (got_i != exp_o);
    nxt_pat_o  = pat(nxt_tgt_i, nxt_idx_i);
  end

endmodule

// File: rtl/i2c_multi_target_tester.sv
// Self-checking I2C traffic sequencer: write/read-back/compare a burst per target.
module i2c_multi_target_tester
  import i2c_test_pkg::*;
#(
  parameter int                         NUM_TARGETS  = 2,
  parameter logic [7*NUM_TARGETS-1:0]   TARGET_ADDRS = {7'h50, 7'h51},
  parameter int                         BURST_LEN    = 4,
  parameter logic [7:0]                 BASE_REG     = 8'h00,
  parameter logic [7:0]                 PAT_SEED     = 8'hA5,
  parameter int                         LOOPS        = 1,
  parameter int                         TIMEOUT_CYC  = 100000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  i2c_multi_target_tester_if.master      bus,
  output logic [2:0]                     test_state,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [15:0]                    err_cnt,
  output logic [31:0]                    first_err,
  output logic                           led_ti,
  output logic                           led_tr
);

  localparam logic [2:0]  LAST_T     = 3'(NUM_TARGETS - 1);
  localparam logic [4:0]  BL5        = 5'(BURST_LEN);
  localparam logic [31:0] WD_LAST    = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] LOOPS32    = 32'(LOOPS);
  localparam logic        LOOPS_FIN  = (LOOPS != 0);

  test_state_e state_q, state_d;
  logic [2:0]  t_q, t_d;
  logic [4:0]  i_q, i_d;
  logic [31:0] loop_q, loop_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] first_err_q, first_err_d;
  logic        txn_valid_q, txn_valid_d;
  logic        txn_rw_q, txn_rw_d;
  logic [6:0]  txn_addr_q, txn_addr_d;
  logic [7:0]  txn_reg_q, txn_reg_d;
  logic [4:0]  txn_len_q, txn_len_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        led_ti_q, led_ti_d;
  logic        led_tr_q, led_tr_d;

  logic        clear_s, txn_end_s, ev_byte_s, ev_term_s, timeout_s, in_txn_q_s;
  logic [31:0] cand_byte_s, cand_term_s;
  logic [4:0]  rd_cnt_s;
  logic [1:0]  err_add_s;
  logic [7:0]  tgt8_s, rd_exp_s, wr_pat_s;
  logic        rd_mismatch_s;
  logic [6:0]  addr_sel_s;

  i2c_test_pattern_chk #(.BURST_LEN(BURST_LEN), .PAT_SEED(PAT_SEED)) u_pat (
    .cur_tgt_i  (t_q),
    .cur_idx_i  (i_q),
    .got_i      (bus.rd_data),
    .nxt_tgt_i  (t_d),
    .nxt_idx_i  (i_d),
    .exp_o      (rd_exp_s),
    .mismatch_o (rd_mismatch_s),
    .nxt_pat_o  (wr_pat_s)
  );

  assign tgt8_s     = {5'd0, t_q};
  assign in_txn_q_s = (state_q == ST_WR_REQ) || (state_q == ST_WR_DATA) ||
                      (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
  assign timeout_s  = in_txn_q_s && (wd_q == WD_LAST);

  // FSM next state, burst index, target/loop advance and error events.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    i_d         = i_q;
    loop_d      = loop_q;
    clear_s     = 1'b0;
    txn_end_s   = 1'b0;
    ev_byte_s   = 1'b0;
    ev_term_s   = 1'b0;
    cand_byte_s = 32'd0;
    cand_term_s = 32'd0;
    rd_cnt_s    = i_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WR_REQ;
          t_d     = 3'd0;
          i_d     = 5'd0;
          loop_d  = 32'd0;
          clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (timeout_s) begin
          state_d     = ST_NEXT;
          ev_term_s   = 1'b1;
          cand_term_s = pack_first_err(tgt8_s, IDX_TIMEOUT, 8'h00, 8'h00);
        end else if (txn_valid_q && bus.txn_ready) begin
          state_d = (state_q == ST_WR_REQ) ? ST_WR_DATA : ST_RD_DATA;
          i_d     = 5'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_DATA: begin
        // Bytes requested past the burst length are not counted.
        if (bus.wr_req && (i_q < BL5)) begin
          i_d = i_q + 5'd1;
        end else begin
          i_d = i_q;
        end
        if (bus.txn_done) begin
          i_d       = 5'd0;
          txn_end_s = 1'b1;
          if (bus.txn_nack) begin
            state_d     = ST_NEXT;
            ev_term_s   = 1'b1;
            cand_term_s = pack_first_err(tgt8_s, IDX_NACK, 8'h00, GOT_NACK);
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (timeout_s) begin
          state_d     = ST_NEXT;
          ev_term_s   = 1'b1;
          cand_term_s = pack_first_err(tgt8_s, IDX_TIMEOUT, 8'h00, 8'h00);
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_DATA: begin
        // The byte arriving with txn_done is compared before the short-read test.
        if (bus.rd_valid && (i_q < BL5)) begin
          rd_cnt_s    = i_q + 5'd1;
          ev_byte_s   = rd_mismatch_s;
          cand_byte_s = pack_first_err(tgt8_s, {3'd0, i_q}, rd_exp_s, bus.rd_data);
        end else begin
          rd_cnt_s = i_q;
        end
        i_d = rd_cnt_s;
        if (bus.txn_done) begin
          i_d       = 5'd0;
          txn_end_s = 1'b1;
          state_d   = ST_NEXT;
          if (bus.txn_nack) begin
            ev_term_s   = 1'b1;
            cand_term_s = pack_first_err(tgt8_s, IDX_NACK, 8'h00, GOT_NACK);
          end else if (rd_cnt_s < BL5) begin
            ev_term_s   = 1'b1;
            cand_term_s = pack_first_err(tgt8_s, {3'd0, rd_cnt_s}, 8'h00, 8'h00);
          end else begin
            ev_term_s = 1'b0;
          end
        end else if (timeout_s) begin
          state_d     = ST_NEXT;
          ev_term_s   = 1'b1;
          cand_term_s = pack_first_err(tgt8_s, IDX_TIMEOUT, 8'h00, 8'h00);
        end else begin
          state_d = state_q;
        end
      end
      ST_NEXT: begin
        i_d = 5'd0;
        if (t_q == LAST_T) begin
          t_d    = 3'd0;
          loop_d = loop_q + 32'd1;
        end else begin
          t_d    = t_q + 3'd1;
          loop_d = loop_q;
        end
        if (stop || (LOOPS_FIN && (loop_d == LOOPS32))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WR_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Address of the target addressed by the request being set up.
  always_comb begin
    addr_sel_s = 7'd0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      addr_sel_s = (t_d == 3'(k)) ? TARGET_ADDRS[7*k +: 7] : addr_sel_s;
    end
  end

  // Watchdog, error accounting and next values of all registered outputs.
  always_comb begin
    if (((state_d == ST_WR_REQ) || (state_d == ST_RD_REQ)) && (state_d != state_q)) begin
      wd_d = 32'd0;
    end else if ((state_d == ST_WR_REQ) || (state_d == ST_WR_DATA) ||
                 (state_d == ST_RD_REQ) || (state_d == ST_RD_DATA)) begin
      wd_d = wd_q + 32'd1;
    end else begin
      wd_d = 32'd0;
    end

    err_add_s = {1'b0, ev_byte_s} + {1'b0, ev_term_s};
    if (clear_s) begin
      err_cnt_d   = 16'd0;
      first_err_d = 32'd0;
    end else begin
      err_cnt_d   = sat_add16(err_cnt_q, err_add_s);
      first_err_d = ((err_cnt_q == 16'd0) && (err_add_s != 2'd0)) ?
                    (ev_byte_s ? cand_byte_s : cand_term_s) : first_err_q;
    end

    txn_valid_d = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    txn_rw_d    = (state_d == ST_RD_REQ) || (state_d == ST_RD_DATA);
    txn_addr_d  = ((state_d == ST_WR_REQ) || (state_d == ST_WR_DATA) ||
                   (state_d == ST_RD_REQ) || (state_d == ST_RD_DATA)) ? addr_sel_s : 7'd0;
    txn_reg_d   = BASE_REG;
    txn_len_d   = BL5;
    wr_data_d   = (state_d == ST_WR_DATA) ? wr_pat_s : 8'h00;
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d      = (state_d == ST_DONE);
    pass_d      = (state_d == ST_DONE) && (err_cnt_d == 16'd0);
    led_tr_d    = pass_d;
    led_ti_d    = led_ti_q ^ txn_end_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t_q         <= 3'd0;
      i_q         <= 5'd0;
      loop_q      <= 32'd0;
      wd_q        <= 32'd0;
      err_cnt_q   <= 16'd0;
      first_err_q <= 32'd0;
      txn_valid_q <= 1'b0;
      txn_rw_q    <= 1'b0;
      txn_addr_q  <= 7'd0;
      txn_reg_q   <= 8'd0;
      txn_len_q   <= 5'd0;
      wr_data_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      led_ti_q    <= 1'b0;
      led_tr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      i_q         <= i_d;
      loop_q      <= loop_d;
      wd_q        <= wd_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      txn_valid_q <= txn_valid_d;
      txn_rw_q    <= txn_rw_d;
      txn_addr_q  <= txn_addr_d;
      txn_reg_q   <= txn_reg_d;
      txn_len_q   <= txn_len_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      led_ti_q    <= led_ti_d;
      led_tr_q    <= led_tr_d;
    end
  end

  assign bus.txn_valid = txn_valid_q;
  assign bus.txn_rw    = txn_rw_q;
  assign bus.txn_addr  = txn_addr_q;
  assign bus.txn_reg   = txn_reg_q;
  assign bus.txn_len   = txn_len_q;
  assign bus.wr_data   = wr_data_q;
  assign test_state    = state_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err     = first_err_q;
  assign led_ti        = led_ti_q;
  assign led_tr        = led_tr_q;

endmodule

// File: tb/tb_i2c_multi_target_tester.sv
// Directed bench: an echoing slave with fault injection drives two sequencer instances.
module tb_i2c_multi_target_tester;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
  logic sel = 1'b0;
  logic s_ready = 1'b0, s_wr_req = 1'b0, s_rd_valid = 1'b0, s_done = 1'b0, s_nack = 1'b0;
  logic [7:0] s_rd_data = 8'h00;

  int checks = 0;
  int failures = 0;
  int toggles = 0;
  logic ledti_prev = 1'b0;
  logic [7:0] mem [0:1][0:3];

  logic [2:0]  st_a, st_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] err_a, err_b;
  logic [31:0] fe_a, fe_b;
  logic        ledti_a, ledti_b, ledtr_a, ledtr_b;

  i2c_multi_target_tester_if ifa();
  i2c_multi_target_tester_if ifb();

  assign ifa.txn_ready = s_ready    & ~sel;
  assign ifa.wr_req    = s_wr_req   & ~sel;
  assign ifa.rd_valid  = s_rd_valid & ~sel;
  assign ifa.txn_done  = s_done     & ~sel;
  assign ifa.txn_nack  = s_nack     & ~sel;
  assign ifa.rd_data   = s_rd_data;
  assign ifb.txn_ready = s_ready    & sel;
  assign ifb.wr_req    = s_wr_req   & sel;
  assign ifb.rd_valid  = s_rd_valid & sel;
  assign ifb.txn_done  = s_done     & sel;
  assign ifb.txn_nack  = s_nack     & sel;
  assign ifb.rd_data   = s_rd_data;

  i2c_multi_target_tester #(.TIMEOUT_CYC(50)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .stop(1'b0), .bus(ifa),
    .test_state(st_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_err(fe_a), .led_ti(ledti_a), .led_tr(ledtr_a)
  );

  i2c_multi_target_tester #(.TIMEOUT_CYC(50), .LOOPS(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .bus(ifb),
    .test_state(st_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_err(fe_b), .led_ti(ledti_b), .led_tr(ledtr_b)
  );

  wire        m_valid   = sel ? ifb.txn_valid : ifa.txn_valid;
  wire        m_rw      = sel ? ifb.txn_rw    : ifa.txn_rw;
  wire [6:0]  m_addr    = sel ? ifb.txn_addr  : ifa.txn_addr;
  wire [7:0]  m_wr_data = sel ? ifb.wr_data   : ifa.wr_data;
  wire [2:0]  m_state   = sel ? st_b   : st_a;
  wire        m_done    = sel ? done_b : done_a;
  wire        m_pass    = sel ? pass_b : pass_a;
  wire [15:0] m_err     = sel ? err_b  : err_a;

  always #5 clk = ~clk;

  // Count led_ti edges of instance A.
  always @(negedge clk) begin
    if (ledti_a !== ledti_prev) toggles = toggles + 1;
    ledti_prev = ledti_a;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=stalled expected=finish");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_pat(input int t, input int k);
    return 8'(8'hA5 + t * 4 + k);
  endfunction

  function automatic logic [6:0] exp_addr(input int t);
    return (t == 0) ? 7'h51 : 7'h50;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (m_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, output int n);
    n = 0;
    while (m_state !== s && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic serve_write(input int t, input bit nack, input bit raise_stop);
    bit ok;
    wait_req(ok);
    chk("wr_req_seen", 32'(ok), 32'd1);
    chk("wr_rw", 32'(m_rw), 32'd0);
    chk("wr_addr", 32'(m_addr), 32'(exp_addr(t)));
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("wr_data", 32'(m_wr_data), 32'(exp_pat(t, k)));
      mem[t][k] = m_wr_data;
      s_wr_req = 1'b1;
      if (raise_stop && k == 1) stop_b = 1'b1;
      if (k == 3) begin
        s_done = 1'b1;
        s_nack = nack;
      end
      @(negedge clk);
      s_wr_req = 1'b0;
      s_done   = 1'b0;
      s_nack   = 1'b0;
    end
  endtask

  task automatic serve_read(input int t, input int corrupt);
    bit ok;
    wait_req(ok);
    chk("rd_req_seen", 32'(ok), 32'd1);
    chk("rd_rw", 32'(m_rw), 32'd1);
    chk("rd_addr", 32'(m_addr), 32'(exp_addr(t)));
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_rd_valid = 1'b1;
      s_rd_data  = (k == corrupt) ? 8'h00 : mem[t][k];
      if (k == 3) s_done = 1'b1;
      @(negedge clk);
      s_rd_valid = 1'b0;
      s_done     = 1'b0;
    end
  endtask

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int n;
    int tog0;
    bit ok;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_valid", 32'(ifa.txn_valid), 32'd0);
    chk("rst_len", 32'(ifa.txn_len), 32'd0);
    chk("rst_wr_data", 32'(ifa.wr_data), 32'd0);
    chk("rst_status", 32'({busy_a, done_a, pass_a, ledti_a, ledtr_a}), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_first_err", fe_a, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run with default parameters.
    tog0 = toggles;
    pulse_start();
    chk("t1_first_wr_req", 32'(st_a), 32'd1);
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_len", 32'(ifa.txn_len), 32'd4);
    chk("t1_reg", 32'(ifa.txn_reg), 32'd0);
    serve_write(0, 1'b0, 1'b0);
    serve_read(0, -1);
    serve_write(1, 1'b0, 1'b0);
    serve_read(1, -1);
    chk("t1_next", 32'(st_a), 32'd5);
    @(negedge clk);
    chk("t1_state_done", 32'(st_a), 32'd6);
    chk("t1_done_pass", 32'({done_a, pass_a, ledtr_a, busy_a}), 32'b1110);
    chk("t1_err", 32'(err_a), 32'd0);
    chk("t1_led_ti_toggles", 32'(toggles - tog0), 32'd4);

    // Byte 2 of target 1 corrupted.
    pulse_start();
    chk("t2_restart", 32'(st_a), 32'd1);
    serve_write(0, 1'b0, 1'b0);
    serve_read(0, -1);
    serve_write(1, 1'b0, 1'b0);
    serve_read(1, 2);
    wait_state(3'd6, n);
    chk("t2_err", 32'(err_a), 32'd1);
    chk("t2_first_err", fe_a, 32'h0102AB00);
    chk("t2_pass_led", 32'({done_a, pass_a, ledtr_a}), 32'b100);

    // Target 0 NACKs its write; next request must be the write to target 1.
    pulse_start();
    chk("t3_err_cleared", 32'(err_a), 32'd0);
    serve_write(0, 1'b1, 1'b0);
    serve_write(1, 1'b0, 1'b0);
    serve_read(1, -1);
    wait_state(3'd6, n);
    chk("t3_err", 32'(err_a), 32'd1);
    chk("t3_first_err", fe_a, 32'h00FF00FF);
    chk("t3_pass", 32'(pass_a), 32'd0);

    // Master accepts but never completes; then never accepts.
    pulse_start();
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    n = 1;
    while (st_a !== 3'd5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_wr_data_cycles", 32'(n), 32'd50);
    chk("t4_err_after_first", 32'(err_a), 32'd1);
    wait_state(3'd1, n);
    chk("t4_t1_valid", 32'(ifa.txn_valid), 32'd1);
    wait_state(3'd5, n);
    chk("t4_timeout_wr_req_cycles", 32'(n), 32'd50);
    chk("t4_valid_dropped", 32'(ifa.txn_valid), 32'd0);
    wait_state(3'd6, n);
    chk("t4_done", 32'(done_a), 32'd1);
    chk("t4_err", 32'(err_a), 32'd2);
    chk("t4_first_err", fe_a, 32'h00FE0000);

    // Reset in the middle of a read burst, then a clean run.
    pulse_start();
    serve_write(0, 1'b0, 1'b0);
    wait_req(ok);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready    = 1'b0;
    s_rd_valid = 1'b1;
    s_rd_data  = 8'h00;
    @(negedge clk);
    s_rd_valid = 1'b0;
    chk("t6_in_rd_data", 32'(st_a), 32'd4);
    chk("t6_err_before_rst", 32'(err_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_state", 32'(st_a), 32'd0);
    chk("t6_bus", 32'({ifa.txn_valid, ifa.txn_rw, ifa.txn_addr}), 32'd0);
    chk("t6_status", 32'({busy_a, done_a, pass_a, ledti_a, ledtr_a}), 32'd0);
    chk("t6_err", 32'(err_a), 32'd0);
    chk("t6_first_err", fe_a, 32'd0);
    pulse_start();
    serve_write(0, 1'b0, 1'b0);
    serve_read(0, -1);
    serve_write(1, 1'b0, 1'b0);
    serve_read(1, -1);
    wait_state(3'd6, n);
    chk("t6_rerun_pass", 32'({done_a, pass_a, ledtr_a}), 32'b111);
    chk("t6_rerun_err", 32'(err_a), 32'd0);

    // Endless loops on instance B, stopped mid-burst in the second pass.
    sel = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("t5_first_wr_req", 32'(m_state), 32'd1);
    serve_write(0, 1'b0, 1'b0);
    serve_read(0, -1);
    serve_write(1, 1'b0, 1'b0);
    serve_read(1, -1);
    serve_write(0, 1'b0, 1'b1);
    serve_read(0, -1);
    chk("t5_next", 32'(m_state), 32'd5);
    @(negedge clk);
    stop_b = 1'b0;
    chk("t5_state_done", 32'(m_state), 32'd6);
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_done_pass", 32'({m_done, m_pass}), 32'b11);
    chk("t5_err", 32'(m_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
